mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Three-port arbiter (data, IO poll, instruction fetch) in front of one single-port RAM.
// Defining MEM_ARB_ROUND_ROBIN_EN swaps fixed data>IO>fetch priority for round-robin.
module mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              io_req,
    input  logic              if_req,
    input  logic              d_we,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              d_ack,
    output logic              io_ack,
    output logic              if_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic [1:0]        grant_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state, w_next;
    logic [2:0]        w_req;
    logic [1:0]        w_winId;
    logic              w_winWe;
    logic [ADDR_W-1:0] w_winAddr;
    logic [DATA_W-1:0] w_winWdata;
    logic [1:0]        r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [2:0]        r_ack;
    logic [DATA_W-1:0] r_dRdata, r_ioRdata, r_ifRdata;

    assign w_req = {if_req, io_req, d_req};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] r_lastGrant;

    // The search starts one past the last winner and wraps 0,1,2.
    always_comb begin
        w_winId = 2'd0;
        case (r_lastGrant)
            2'd0: begin
                if (w_req[1])      w_winId = 2'd1;
                else if (w_req[2]) w_winId = 2'd2;
                else               w_winId = 2'd0;
            end
            2'd1: begin
                if (w_req[2])      w_winId = 2'd2;
                else if (w_req[0]) w_winId = 2'd0;
                else               w_winId = 2'd1;
            end
            default: begin
                if (w_req[0])      w_winId = 2'd0;
                else if (w_req[1]) w_winId = 2'd1;
                else               w_winId = 2'd2;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_lastGrant <= 2'd2;
        else if (r_state == IDLE && (|w_req))
            r_lastGrant <= w_winId;
    end
`else
    always_comb begin
        w_winId = 2'd2;
        if (d_req)       w_winId = 2'd0;
        else if (io_req) w_winId = 2'd1;
    end
`endif

    // Fetch is read-only, so its write qualifier is forced low here.
    always_comb begin
        w_winWe    = 1'b0;
        w_winAddr  = if_addr;
        w_winWdata = '0;
        case (w_winId)
            2'd0: begin
                w_winWe    = d_we;
                w_winAddr  = d_addr;
                w_winWdata = d_wdata;
            end
            2'd1: begin
                w_winWe    = io_we;
                w_winAddr  = io_addr;
                w_winWdata = io_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b1;
        grant_id = r_id;
        mem_we   = 1'b0;
        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                grant_id = 2'd3;
                if (|w_req) w_next = ACCESS;
            end
            ACCESS: begin
                mem_we = r_we & ~rst;
                w_next = RESP;
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Ack is raised on the ACCESS->RESP edge, so a reset during ACCESS suppresses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id      <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_ack     <= '0;
            r_dRdata  <= '0;
            r_ioRdata <= '0;
            r_ifRdata <= '0;
        end else begin
            r_ack <= '0;
            if (r_state == IDLE && (|w_req)) begin
                r_id    <= w_winId;
                r_we    <= w_winWe;
                r_addr  <= w_winAddr;
                r_wdata <= w_winWdata;
            end
            if (r_state == ACCESS)
                r_ack <= 3'b001 << r_id;
            if (r_state == RESP && !r_we) begin
                case (r_id)
                    2'd0:    r_dRdata  <= mem_dout;
                    2'd1:    r_ioRdata <= mem_dout;
                    default: r_ifRdata <= mem_dout;
                endcase
            end
        end
    end

    assign d_ack    = r_ack[0];
    assign io_ack   = r_ack[1];
    assign if_ack   = r_ack[2];
    assign d_rdata  = r_dRdata;
    assign io_rdata = r_ioRdata;
    assign if_rdata = r_ifRdata;
    assign mem_addr = r_addr;
    assign mem_din  = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read RAM model; the grant expectations
// of the held-request sequence follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_req, io_req, if_req, d_we, io_we;
    logic [12:0] d_addr, io_addr, if_addr;
    logic [31:0] d_wdata, io_wdata;
    logic        d_ack, io_ack, if_ack;
    logic [31:0] d_rdata, io_rdata, if_rdata;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din, mem_dout;
    logic        busy;
    logic [1:0]  grant_id;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram [0:8191];

    int expAckTab[8]   = '{0, 1, 0, 0, 2, 0, 0, 4};
    int expGrantTab[8] = '{0, 0, 3, 1, 1, 3, 2, 2};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    int expHeldTab[6]  = '{0, 1, 2, 0, 1, 2};
`else
    int expHeldTab[6]  = '{0, 0, 0, 0, 0, 0};
`endif

    mem_arbiter #(.ADDR_W(13), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .io_req(io_req), .if_req(if_req),
        .d_we(d_we), .io_we(io_we),
        .d_addr(d_addr), .io_addr(io_addr), .if_addr(if_addr),
        .d_wdata(d_wdata), .io_wdata(io_wdata),
        .d_ack(d_ack), .io_ack(io_ack), .if_ack(if_ack),
        .d_rdata(d_rdata), .io_rdata(io_rdata), .if_rdata(if_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read (read-before-write).
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic waitCycle();
        @(negedge clk);
    endtask

    task automatic clearRequests();
        d_req = 0; io_req = 0; if_req = 0;
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [12:0] addr, input logic [31:0] wdata);
        case (port)
            0: begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata; end
            1: begin io_req = 1; io_we = we; io_addr = addr; io_wdata = wdata; end
            default: begin if_req = 1; if_addr = addr; end
        endcase
    endtask

    function automatic logic [31:0] ackVec();
        return {29'd0, if_ack, io_ack, d_ack};
    endfunction

    task automatic serveOne(input string tag, input int port, input logic we, input logic [12:0] addr, input logic [31:0] wdata);
        applyStimulus(port, we, addr, wdata);
        waitCycle();
        checkOutput({tag, "_grant"}, {30'd0, grant_id}, port);
        checkOutput({tag, "_memWe"}, {31'd0, mem_we}, {31'd0, we});
        checkOutput({tag, "_memAddr"}, {19'd0, mem_addr}, {19'd0, addr});
        if (we) checkOutput({tag, "_memDin"}, mem_din, wdata);
        waitCycle();
        checkOutput({tag, "_ack"}, ackVec(), 32'd1 << port);
        checkOutput({tag, "_memWeResp"}, {31'd0, mem_we}, 32'd0);
        clearRequests();
        waitCycle();
        checkOutput({tag, "_ackIdle"}, ackVec(), 32'd0);
        checkOutput({tag, "_busyIdle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1;
        clearRequests();
        d_we = 0; io_we = 0;
        d_addr = 0; io_addr = 0; if_addr = 0;
        d_wdata = 0; io_wdata = 0;
        repeat (3) waitCycle();
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_grant", {30'd0, grant_id}, 32'd3);
        checkOutput("rst_acks", ackVec(), 32'd0);
        checkOutput("rst_memWe", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_memAddr", {19'd0, mem_addr}, 32'd0);
        checkOutput("rst_dRdata", d_rdata, 32'd0);
        checkOutput("rst_ifRdata", if_rdata, 32'd0);
        rst = 0;
        waitCycle();

        serveOne("dWr10", 0, 1'b1, 13'h0010, 32'hDEADBEEF);
        checkOutput("dWr10_rdataKept", d_rdata, 32'd0);
        serveOne("ifRd10", 2, 1'b0, 13'h0010, 32'd0);
        checkOutput("ifRd10_rdata", if_rdata, 32'hDEADBEEF);

        serveOne("dWr1FFF", 0, 1'b1, 13'h1FFF, 32'h12345678);
        serveOne("dRd1FFF", 0, 1'b0, 13'h1FFF, 32'd0);
        checkOutput("dRd1FFF_rdata", d_rdata, 32'h12345678);
        checkOutput("ifRdata_held", if_rdata, 32'hDEADBEEF);
        checkOutput("ioRdata_untouched", io_rdata, 32'd0);

        serveOne("dWr5", 0, 1'b1, 13'h0005, 32'hAAAA5555);
        applyStimulus(1, 1'b1, 13'h0005, 32'h11111111);
        waitCycle();
        checkOutput("ioWr5_grant", {30'd0, grant_id}, 32'd1);
        checkOutput("ioWr5_memWe", {31'd0, mem_we}, 32'd1);
        rst = 1;
        #1;
        checkOutput("rstAccess_memWe", {31'd0, mem_we}, 32'd0);
        waitCycle();
        checkOutput("rstAccess_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstAccess_grant", {30'd0, grant_id}, 32'd3);
        checkOutput("rstAccess_noAck", ackVec(), 32'd0);
        rst = 0;
        clearRequests();
        waitCycle();
        checkOutput("rstAccess_noLateAck", ackVec(), 32'd0);
        serveOne("dRd5", 0, 1'b0, 13'h0005, 32'd0);
        checkOutput("dRd5_unchanged", d_rdata, 32'hAAAA5555);

        rst = 1;
        waitCycle();
        rst = 0;
        applyStimulus(0, 1'b0, 13'h0010, 32'd0);
        applyStimulus(1, 1'b0, 13'h1FFF, 32'd0);
        applyStimulus(2, 1'b0, 13'h0005, 32'd0);
        for (int c = 1; c <= 8; c++) begin
            waitCycle();
            checkOutput($sformatf("simul_ack_c%0d", c), ackVec(), expAckTab[c-1]);
            checkOutput($sformatf("simul_grant_c%0d", c), {30'd0, grant_id}, expGrantTab[c-1]);
            if (c == 2) d_req = 0;
            if (c == 5) io_req = 0;
            if (c == 8) if_req = 0;
        end
        waitCycle();
        checkOutput("simul_dRdata", d_rdata, 32'hDEADBEEF);
        checkOutput("simul_ioRdata", io_rdata, 32'h12345678);
        checkOutput("simul_ifRdata", if_rdata, 32'hAAAA5555);

        applyStimulus(0, 1'b0, 13'h0010, 32'd0);
        applyStimulus(1, 1'b0, 13'h1FFF, 32'd0);
        applyStimulus(2, 1'b0, 13'h0005, 32'd0);
        for (int c = 1; c <= 18; c++) begin
            waitCycle();
            if (c % 3 == 1)
                checkOutput($sformatf("held_grant_%0d", c / 3), {30'd0, grant_id}, expHeldTab[c / 3]);
            if (c % 3 == 2)
                checkOutput($sformatf("held_ack_%0d", c / 3), ackVec(), 32'd1 << expHeldTab[c / 3]);
            if (c == 17) clearRequests();
        end
        checkOutput("held_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
